// File: rtl/threebit_serial_sub_if.sv
// Start/busy/done handshake bundle for the bit-serial subtractor.
// The controller drives the master side; the subtractor sits on the slave side.
interface threebit_serial_sub_if #(parameter int WIDTH = 3);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  modport master (output start, x, y, input  busy, done, d, bout);
  modport slave  (input  start, x, y, output busy, done, d, bout);
endinterface

// File: rtl/threebit_serial_sub.sv
// Bit-serial x - y, LSB first, over WIDTH cycles with start/busy/done handshake.
// Optional SERIAL_SUB_SATURATE_EN clamps the committed difference to 0 on borrow.
module threebit_serial_sub #(
  parameter int WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  threebit_serial_sub_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [WIDTH-1:0] res_q, res_d, d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             b_q, b_d, bout_q, bout_d;
  logic             diff_bit, b_next;
  logic [WIDTH-1:0] res_shift;

  // Operands shift right each cycle so the active bit is always bit 0.
  assign diff_bit  = x_q[0] ^ y_q[0] ^ b_q;
  assign b_next    = (~x_q[0] & y_q[0]) | (~(x_q[0] ^ y_q[0]) & b_q);
  assign res_shift = {diff_bit, res_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      b_q     <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      bout_q  <= bout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = bus.x;
          y_d     = bus.y;
          res_d   = '0;
          cnt_d   = '0;
          b_d     = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        x_d   = x_q >> 1;
        y_d   = y_q >> 1;
        res_d = res_shift;
        b_d   = b_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Commit uses the shifted value so the final bit lands in d.
`ifdef SERIAL_SUB_SATURATE_EN
          d_d = b_next ? '0 : res_shift;
`else
          d_d = res_shift;
`endif
          bout_d  = b_next;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.d    = d_q;
  assign bus.bout = bout_q;
endmodule

// File: tb/tb_threebit_serial_sub.sv
// Directed bench for threebit_serial_sub: stimulus pushes expected results,
// a forked monitor pops and compares on every done pulse.
module tb_threebit_serial_sub;
  localparam int W = 3;

  typedef struct packed {
    logic [W-1:0] d;
    logic         b;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   rst_cnt = 0;
  int   seen_rst = 0;
  logic [W-1:0] prev_d = '0;
  exp_t sb[$];

  threebit_serial_sub_if #(.WIDTH(W)) bus ();

  threebit_serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Pops on each done; between commits d must hold unless a reset intervened.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_d", int'(bus.d), int'(e.d));
          chk("sb_bout", int'(bus.bout), int'(e.b));
        end
      end else if (rst_n && seen_rst == rst_cnt) begin
        chk("d_hold", int'(bus.d), int'(prev_d));
      end
      prev_d   = bus.d;
      seen_rst = rst_cnt;
    end
  endtask

  function automatic logic [W-1:0] sat_d(input logic [W-1:0] wrap, input logic b);
`ifdef SERIAL_SUB_SATURATE_EN
    return b ? '0 : wrap;
`else
    return wrap;
`endif
  endfunction

  // One operation with handshake timing checks; k counts negedges after E0.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ed, input logic eb);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1; bus.x = a; bus.y = b;
    e.d = ed; e.b = eb;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0; bus.x = ~a; bus.y = ~b;
    chk("busy_e0", int'(bus.busy), 1);
    chk("done_e0", int'(bus.done), 0);
    @(negedge clk); chk("busy_e1", int'(bus.busy), 1);
    @(negedge clk); chk("busy_e2", int'(bus.busy), 1);
    @(negedge clk);
    chk("done_e3", int'(bus.done), 1);
    chk("busy_e3", int'(bus.busy), 0);
    @(negedge clk);
    chk("done_e4", int'(bus.done), 0);
  endtask

  initial begin
    exp_t e;
    int   ndone;
    bus.start = 1'b0; bus.x = '0; bus.y = '0;
    fork monitor(); join_none

    #12;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_d",    int'(bus.d),    0);
    chk("rst_bout", int'(bus.bout), 0);
    @(negedge clk); rst_n = 1'b1;

    run_op(3'd5, 3'd2, 3'd3, 1'b0);
    run_op(3'd3, 3'd4, sat_d(3'd7, 1'b1), 1'b1);
    run_op(3'd7, 3'd7, 3'd0, 1'b0);
    run_op(3'd6, 3'd3, 3'd3, 1'b0);
    run_op(3'd0, 3'd7, sat_d(3'd1, 1'b1), 1'b1);

    // Start held through SHIFT with new operands must not be queued.
    @(negedge clk);
    bus.start = 1'b1; bus.x = 3'd6; bus.y = 3'd1;
    e.d = 3'd5; e.b = 1'b0; sb.push_back(e);
    @(negedge clk); bus.x = 3'd0; bus.y = 3'd5;
    chk("ign_busy", int'(bus.busy), 1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); bus.start = 1'b0;
    chk("ign_done", int'(bus.done), 1);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("ign_no_second", ndone, 0);

    // Reset one SHIFT cycle into an operation.
    @(negedge clk);
    bus.start = 1'b1; bus.x = 3'd5; bus.y = 3'd2;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    #2 rst_cnt++; rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    chk("mid_rst_d",    int'(bus.d),    0);
    chk("mid_rst_bout", int'(bus.bout), 0);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("mid_rst_no_done", ndone, 0);

    // Back-to-back with start held: commits 5 cycles apart, d holds in between.
    @(negedge clk);
    bus.start = 1'b1; bus.x = 3'd4; bus.y = 3'd1;
    e.d = 3'd3; e.b = 1'b0; sb.push_back(e);
    e.d = 3'd0; e.b = 1'b0; sb.push_back(e);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin bus.x = 3'd2; bus.y = 3'd2; end
      if (k == 5) bus.start = 1'b0;
      chk($sformatf("b2b_done_k%0d", k), int'(bus.done), (k == 3 || k == 8) ? 1 : 0);
      if (k >= 4 && k <= 7) chk($sformatf("b2b_hold_k%0d", k), int'(bus.d), 3);
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
